// File: rtl/merge_pkg.sv
// Shared definitions for the merge network and its consumers.
//   WIDTH  : bits per element (key width)
//   N      : elements per merger input list; a merged frame holds 2*N
//   IDXW   : width of an element index within a merged frame
//   state_t: serializer FSM states
//   elem_t : one element
package merge_pkg;

    localparam int WIDTH = 3;
    localparam int N     = 8;
    localparam int IDXW  = $clog2(2 * N);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [WIDTH-1:0] elem_t;

endpackage

// File: rtl/merged_list_serializer.sv
// Streams a packed merged frame of 2*N sorted elements out one element per
// cycle (element 0 first) under valid/ready, and raises a sticky flag if any
// emitted element is smaller than its predecessor within the same frame.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  frame handshake; in_data is the packed frame,
//                        element i at [(i+1)*WIDTH-1 : i*WIDTH]
//   out_valid/out_ready  element handshake
//   out_data             current element
//   out_index            position of out_data within the frame
//   out_last             current element is the final one of the frame
//   order_err            sticky ordering-violation flag, cleared only by rst
module merged_list_serializer #(
    parameter int WIDTH = merge_pkg::WIDTH,
    parameter int N     = merge_pkg::N,
    parameter int IDXW  = $clog2(2 * N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*N*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_index,
    output logic                   out_last,
    output logic                   order_err
);

    import merge_pkg::*;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * N - 1);

    state_t                 state_q, state_d;
    logic [2*N*WIDTH-1:0]   sreg_q,  sreg_d;
    logic [IDXW-1:0]        idx_q,   idx_d;
    logic [WIDTH-1:0]       prev_q,  prev_d;
    logic                   prev_vld_q, prev_vld_d;
    logic                   err_q,   err_d;

    logic                   beat;
    logic                   accept;

    assign out_valid = (state_q == SEND);
    assign out_data  = sreg_q[WIDTH-1:0];
    assign out_index = idx_q;
    assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign order_err = err_q;

    // Accepting on the last beat's cycle lets frames run back to back.
    assign in_ready  = !rst && ((state_q == IDLE) || (out_last && out_ready));

    assign beat      = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        err_d      = err_q;

        if (beat) begin
            sreg_d     = sreg_q >> WIDTH;
            prev_d     = out_data;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (out_data < prev_q)) begin
                err_d = 1'b1;
            end
            // idx holds at the final position rather than wrapping; only a
            // new accept returns it to 0.
            if (out_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A new frame overrides the post-beat update; prev is invalidated so
        // element 0 is never compared against the previous frame's tail.
        if (accept) begin
            state_d    = SEND;
            sreg_d     = in_data;
            idx_d      = '0;
            prev_d     = '0;
            prev_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            idx_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_merged_list_serializer.sv
// Scoreboard bench for merged_list_serializer: the frame driver pushes the
// expected beat sequence on each accept, a monitor pops and compares every
// transferred beat, and a separate process drives out_ready patterns.
module tb_merged_list_serializer;

    localparam int W  = 3;
    localparam int NE = 16;
    localparam int FW = NE * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic          order_err;

    merged_list_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .order_err (order_err)
    );

    typedef struct {
        logic [W-1:0] d;
        int           idx;
        bit           last;
        bit           err;
    } exp_t;

    exp_t q[$];
    bit   err_model;
    int   nchk;
    int   nerr;
    int   rmode;   // 0: always ready, 1: pattern 1,0,0,1, 2: random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] pack(input logic [W-1:0] e[NE]);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NE; i++) f[i*W +: W] = e[i];
        return f;
    endfunction

    // Expected beats follow directly from the frame contents: element i at
    // index i, last at 15, and the flag seen during a beat is the running
    // OR of all earlier in-frame descents.
    task automatic model_push(input logic [W-1:0] e[NE]);
        exp_t x;
        for (int i = 0; i < NE; i++) begin
            x.d    = e[i];
            x.idx  = i;
            x.last = (i == NE - 1);
            x.err  = err_model;
            q.push_back(x);
            if (i > 0 && e[i] < e[i-1]) err_model = 1'b1;
        end
    endtask

    task automatic gen(output logic [W-1:0] e[NE], input bit sorted);
        int v[$];
        for (int i = 0; i < NE; i++) v.push_back(int'($urandom_range(0, 7)));
        if (sorted) v.sort();
        for (int i = 0; i < NE; i++) e[i] = v[i][W-1:0];
    endtask

    task automatic send_frame(input logic [W-1:0] e[NE], input bit b2b);
        bit acc;
        bit during;
        bit lst;
        acc    = 1'b0;
        during = 1'b0;
        lst    = 1'b0;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pack(e);
            #1;
            if (in_ready) begin
                acc    = 1'b1;
                during = out_valid;
                lst    = out_last;
                model_push(e);
            end
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            return;
        end
        if (b2b) check("b2b_accept_on_last_beat", int'(during && lst), 1);
        @(posedge clk);
        #1;
        check("latency_valid", int'(out_valid), 1);
        check("latency_index", int'(out_index), 0);
        check("latency_data", int'(out_data), int'(e[0]));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 2000 && q.size() > 0; c++) @(negedge clk);
        check("drain_timeout", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // out_ready driver
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                1:       begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare every transferred beat, and hold/ready rules on stalls.
    initial begin
        exp_t         x;
        bit           stall_prev;
        logic [W-1:0] sd;
        logic [3:0]   si;
        logic         sl;
        stall_prev = 1'b0;
        sd = '0; si = '0; sl = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && out_valid) begin
                    check("stall_hold_data", int'(out_data), int'(sd));
                    check("stall_hold_index", int'(out_index), int'(si));
                    check("stall_hold_last", int'(out_last), int'(sl));
                end
                if (out_valid && !out_last) check("in_ready_low_mid_frame", int'(in_ready), 0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        x = q.pop_front();
                        check("beat_data", int'(out_data), int'(x.d));
                        check("beat_index", int'(out_index), x.idx);
                        check("beat_last", int'(out_last), int'(x.last));
                        check("beat_order_err", int'(order_err), int'(x.err));
                    end
                end
                stall_prev = out_valid && !out_ready;
                sd = out_data; si = out_index; sl = out_last;
            end
        end
    end

    initial begin
        logic [W-1:0] f1[NE];
        logic [W-1:0] fa[NE];
        logic [W-1:0] fb[NE];
        logic [W-1:0] fbad[NE];
        int found;

        nchk = 0; nerr = 0; err_model = 1'b0; rmode = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;

        // merge of a = {7 x 8} with b = {1,3,4,6,7,7,7,7}
        f1[0] = 3'd1; f1[1] = 3'd3; f1[2] = 3'd4; f1[3] = 3'd6;
        for (int i = 4; i < NE; i++) f1[i] = 3'd7;
        for (int i = 0; i < NE; i++) fa[i] = 3'd7;
        for (int i = 0; i < NE; i++) fb[i] = (i < 8) ? 3'(i) : 3'd7;
        for (int i = 0; i < NE; i++) fbad[i] = f1[i];
        fbad[4] = 3'd2;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready_during_rst", int'(in_ready), 0);
        check("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_index", int'(out_index), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_order_err", int'(order_err), 0);

        // full-rate frame
        send_frame(f1, 1'b0); idle(); drain();
        check("clean_order_err", int'(order_err), 0);

        // same frame under 1,0,0,1 backpressure
        rmode = 1;
        send_frame(f1, 1'b0); idle(); drain();
        rmode = 0;

        // two random sorted frames back to back
        gen(fa, 1'b1); send_frame(fa, 1'b0);
        gen(fa, 1'b1); send_frame(fa, 1'b1);
        idle(); drain();

        // all-7 frame followed by an ascending frame: no cross-frame compare
        for (int i = 0; i < NE; i++) fa[i] = 3'd7;
        send_frame(fa, 1'b0); send_frame(fb, 1'b1); idle(); drain();
        check("no_cross_frame_err", int'(order_err), 0);

        // descent at index 4, then clean frames keep the flag
        send_frame(fbad, 1'b0); send_frame(f1, 1'b1); send_frame(fb, 1'b1);
        idle(); drain();
        check("order_err_sticky", int'(order_err), 1);

        // randomized frames and randomized backpressure
        rmode = 2;
        for (int k = 0; k < 20; k++) begin
            gen(fa, ($urandom_range(0, 2) != 0));
            send_frame(fa, 1'b0);
        end
        idle(); drain();
        rmode = 0;

        // reset in the middle of a frame
        gen(fa, 1'b1);
        send_frame(fa, 1'b0); idle();
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_index == 4'd5) found = 1;
        end
        check("reach_index5", found, 1);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        err_model = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_order_err", int'(order_err), 0);
        check("midrst_out_index", int'(out_index), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_out_data", int'(out_data), 0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        gen(fa, 1'b1);
        send_frame(fa, 1'b0); idle(); drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
